ddr_clkmux_sel_ctrl: RTL

Sequencer that drives the 2-bit select and downstream clock-gate enable of a 3:1 differential PHY clock mux. It makes select changes glitch-safe:
- gate the muxed clock off, hold, switch the select, let the mux settle, then re-enable the gate.
- Sits in the wddr clock-control path, one instance per mux, in the always-on control clock domain (not the muxed clock).

---
 rtl/ddr_clkmux_sel_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ddr_clkmux_sel_ctrl.sv
`default_nettype none
// ==========================================================================
// ddr_clkmux_sel_ctrl - glitch-safe select/gate sequencer for a 3:1 PHY clock mux.
// Optional DDR_CLKMUX_SEL_CTRL_CNT_EN adds o_switch_cnt. Rev 1.0
// ==========================================================================
module ddr_clkmux_sel_ctrl #(
  parameter logic [1:0] RESET_SEL  = 2'b01,
  parameter int         GATE_CYC   = 4,
  parameter int         SETTLE_CYC = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  input  logic [1:0] i_req_sel,
  output logic       o_req_ready,
  output logic [1:0] o_sel,
  output logic       o_gate_en,
  output logic       o_done,
  output logic       o_err,
  output logic       o_busy
`ifdef DDR_CLKMUX_SEL_CTRL_CNT_EN
  ,
  output logic [7:0] o_switch_cnt
`endif
);

  localparam logic [7:0] GATE_LOAD   = 8'(GATE_CYC - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_GATE_OFF = 2'd2,
    ST_SETTLE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] pend_q, pend_d;
  logic       gate_q, gate_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       switch_now;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    pend_d     = pend_q;
    gate_d     = gate_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    switch_now = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == 8'd0) begin
          gate_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_IDLE: begin
        if (i_req_valid) begin
          if (i_req_sel == 2'b00) begin
            err_d = 1'b1;
          end else if (i_req_sel == sel_q) begin
            done_d = 1'b1;
          end else begin
            pend_d  = i_req_sel;
            gate_d  = 1'b0;
            cnt_d   = GATE_LOAD;
            state_d = ST_GATE_OFF;
          end
        end
      end
      ST_GATE_OFF: begin
        // Gate has been off long enough; the mux select may now move.
        if (cnt_q == 8'd0) begin
          sel_d      = pend_q;
          cnt_d      = SETTLE_LOAD;
          state_d    = ST_SETTLE;
          switch_now = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) begin
          gate_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = SETTLE_LOAD;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_INIT;
      cnt_q   <= SETTLE_LOAD;
      sel_q   <= RESET_SEL;
      pend_q  <= RESET_SEL;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_sel       = sel_q;
  assign o_gate_en   = gate_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

`ifdef DDR_CLKMUX_SEL_CTRL_CNT_EN
  logic [7:0] swcnt_q, swcnt_d;

  always_comb begin
    swcnt_d = swcnt_q;
    if (switch_now && (swcnt_q != 8'hFF)) begin
      swcnt_d = swcnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      swcnt_q <= 8'd0;
    end else begin
      swcnt_q <= swcnt_d;
    end
  end

  assign o_switch_cnt = swcnt_q;
`else
  logic unused_switch_now;
  assign unused_switch_now = switch_now;
`endif

endmodule
`default_nettype wire
